// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Imported by mem_arbiter and mem_arb_timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_e;

  localparam logic [31:0] ARB_ERR_DATA        = 32'hDEADBEEF;
  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;

  // A tie goes to whichever port did not win the previous grant.
  function automatic arb_port_e arb_pick(input logic elig_i, input logic elig_d,
                                         input arb_port_e last);
    arb_port_e pick;
    if (elig_i && elig_d) begin
      pick = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (elig_d) begin
      pick = PORT_D;
    end else begin
      pick = PORT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy-cycle watchdog for mem_arbiter; instantiated only when MEM_ARB_TIMEOUT_EN is defined.
// expired is high in the busy cycle that would be the TIMEOUT_CYCLES-th one without an ack.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single request/ack memory port.
// Optional busy timeout with error reporting is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        err,
  output logic [31:0] err_addr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e  state_q, state_d;
  arb_port_e   last_q, last_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;

  logic        elig_i, elig_d, grant, busy, timeout_hit, finish;
  logic [31:0] fin_data;
  arb_port_e   gnt_port;

  // A port that is being handed its ready pulse is not eligible that cycle.
  assign elig_i   = if_req & ~if_ready_q;
  assign elig_d   = d_req & ~d_ready_q;
  assign busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign grant    = (state_q == IDLE) && (elig_i || elig_d);
  assign gnt_port = arb_pick(elig_i, elig_d, last_q);

`ifdef MEM_ARB_TIMEOUT_EN
  logic        to_expired;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (grant),
    .enable (busy & ~mem_ack),
    .expired(to_expired)
  );

  assign timeout_hit = to_expired;

  always_comb begin
    err_d      = busy & ~mem_ack & timeout_hit;
    err_addr_d = err_d ? mem_addr_q : err_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign err_addr    = '0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    finish      = 1'b0;
    fin_data    = mem_rdata;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          last_d    = gnt_port;
          mem_req_d = 1'b1;
          if (gnt_port == PORT_D) begin
            state_d     = BUSY_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = BUSY_I;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack arriving together with expiry wins: the access completes normally.
        if (mem_ack) begin
          finish = 1'b1;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          fin_data = ARB_ERR_DATA;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    if (finish) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == BUSY_D) begin
        d_ready_d = 1'b1;
        if (!mem_we_q) begin
          d_rdata_d = fin_data;
        end
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= PORT_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign stall     = elig_i | elig_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, err_addr;
  logic        if_ready, d_ready, mem_req, mem_we, stall, err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model: one outstanding transaction record plus the visible outputs.
  bit          m_busy, m_is_d, m_we, m_last_d, m_if_rdy, m_d_rdy, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata, m_err_addr;
  int          m_wait;

  task automatic model_reset();
    m_busy = 0; m_is_d = 0; m_we = 0; m_last_d = 0; m_if_rdy = 0; m_d_rdy = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0; m_err_addr = '0; m_wait = 0;
  endtask

  task automatic model_complete(input logic [31:0] data);
    m_busy = 0;
    if (m_is_d) begin
      m_d_rdy = 1;
      if (!m_we) m_d_rdata = data;
    end else begin
      m_if_rdy = 1;
      m_if_rdata = data;
    end
  endtask

  task automatic model_step();
    bit ei, ed, pick_d;
    ei = if_req && !m_if_rdy;
    ed = d_req && !m_d_rdy;
    m_if_rdy = 0;
    m_d_rdy  = 0;
    m_err    = 0;
    if (!m_busy) begin
      if (ei || ed) begin
        pick_d   = ed && (!ei || !m_last_d);
        m_last_d = pick_d;
        m_busy   = 1;
        m_is_d   = pick_d;
        m_we     = pick_d ? d_we : 1'b0;
        m_addr   = pick_d ? d_addr : if_addr;
        m_wdata  = pick_d ? d_wdata : 32'h0;
        m_wait   = 0;
      end
    end else if (mem_ack) begin
      model_complete(mem_rdata);
    end else begin
      m_wait++;
      if (TO_EN && m_wait == int'(TO)) begin
        m_err      = 1;
        m_err_addr = m_addr;
        model_complete(32'hDEADBEEF);
      end
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic        e_irdy;
    logic        e_drdy;
    logic [31:0] e_ird;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // single fetch, store with address change while busy, back-to-back load, stray ack
    tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0};
    tbl[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'h13,
               1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h13, 32'h0};
    tbl[2] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h13, 32'h0};
    tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 32'h13, 32'h0};
    tbl[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 1'b0, 1'b0, 32'h13, 32'h0};
    tbl[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h300, 32'h12345678, 1'b1, 32'h55AA55AA,
               1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h13, 32'h0};
    tbl[6] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h13, 32'h0};
    tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h104, 32'h0,        1'b0, 1'b0, 32'h13, 32'h0};
    tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h104, 32'h0,        1'b1, 32'hA5A50104,
               1'b1, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h13, 32'hA5A50104};
    tbl[9] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 32'hFFFFFFFF,
               1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h13, 32'hA5A50104};

    idle_inputs();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if_req = tbl[k].ireq;   if_addr = tbl[k].iaddr;
      d_req = tbl[k].dreq;    d_we = tbl[k].dwe;
      d_addr = tbl[k].daddr;  d_wdata = tbl[k].dwdata;
      mem_ack = tbl[k].ack;   mem_rdata = tbl[k].rdata;
      #1;
      chk1($sformatf("tbl%0d_stall", k), stall, tbl[k].e_stall);
      tick();
      chk1($sformatf("tbl%0d_mem_req", k), mem_req, tbl[k].e_mreq);
      if (tbl[k].e_mreq) begin
        chk1($sformatf("tbl%0d_mem_we", k), mem_we, tbl[k].e_mwe);
        chk32($sformatf("tbl%0d_mem_addr", k), mem_addr, tbl[k].e_maddr);
      end
      if (tbl[k].e_mwe) chk32($sformatf("tbl%0d_mem_wdata", k), mem_wdata, tbl[k].e_mwdata);
      chk1($sformatf("tbl%0d_if_ready", k), if_ready, tbl[k].e_irdy);
      chk1($sformatf("tbl%0d_d_ready", k), d_ready, tbl[k].e_drdy);
      chk32($sformatf("tbl%0d_if_rdata", k), if_rdata, tbl[k].e_ird);
      chk32($sformatf("tbl%0d_d_rdata", k), d_rdata, tbl[k].e_drd);
    end

    // Tie from reset: data wins, fetch follows; three wait cycles each
    rst = 1'b0;
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("tie_stall0", stall, 1'b1);
    tick();
    chk1("tie_d_mem_req", mem_req, 1'b1);
    chk32("tie_d_addr", mem_addr, 32'h100);
    chk1("tie_d_we", mem_we, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk1("tie_d_wait_req", mem_req, 1'b1);
      chk1("tie_d_wait_stall", stall, 1'b1);
      chk1("tie_d_wait_rdy", d_ready, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hD0D00100;
    tick();
    mem_ack = 1'b0;
    chk1("tie_d_ready", d_ready, 1'b1);
    chk1("tie_d_if_ready", if_ready, 1'b0);
    chk32("tie_d_rdata", d_rdata, 32'hD0D00100);
    chk1("tie_d_stall_fetch", stall, 1'b1);
    d_req = 1'b0;
    tick();
    chk1("tie_i_mem_req", mem_req, 1'b1);
    chk32("tie_i_addr", mem_addr, 32'h80);
    chk1("tie_i_d_ready_pulse", d_ready, 1'b0);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk1("tie_i_wait_stall", stall, 1'b1);
      chk1("tie_i_wait_rdy", if_ready, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    mem_ack = 1'b0;
    chk1("tie_i_ready", if_ready, 1'b1);
    chk32("tie_i_rdata", if_rdata, 32'h13579BDF);
    chk1("tie_i_stall", stall, 1'b0);
    if_req = 1'b0;

    // Reset during a data access, ack arrives after release
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    tick();
    chk1("rmid_busy", mem_req, 1'b1);
    d_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk1("rmid_async_req", mem_req, 1'b0);
    chk32("rmid_async_addr", mem_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    chk1("rmid_no_d_ready", d_ready, 1'b0);
    chk1("rmid_idle_req", mem_req, 1'b0);
    chk32("rmid_d_rdata", d_rdata, 32'h0);
    tick();
    chk1("rmid_no_d_ready2", d_ready, 1'b0);
    chk1("rmid_no_if_ready", if_ready, 1'b0);

    // Fetch that is never acked
    do_reset();
    if_req = 1'b1; if_addr = 32'h4000;
    tick();
    if_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 0; k < int'(TO); k++) begin
      chk1("to_busy_req", mem_req, 1'b1);
      chk1("to_no_err", err, 1'b0);
      tick();
    end
    chk1("to_req_drop", mem_req, 1'b0);
    chk1("to_err", err, 1'b1);
    chk32("to_err_addr", err_addr, 32'h4000);
    chk1("to_if_ready", if_ready, 1'b1);
    chk32("to_if_rdata", if_rdata, 32'hDEADBEEF);
    tick();
    chk1("to_err_pulse", err, 1'b0);
    chk1("to_ready_pulse", if_ready, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      chk1("nto_busy_req", mem_req, 1'b1);
      chk1("nto_err", err, 1'b0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000600D;
    tick();
    mem_ack = 1'b0;
    chk1("nto_if_ready", if_ready, 1'b1);
    chk32("nto_if_rdata", if_rdata, 32'h0000600D);
    chk32("nto_err_addr", err_addr, 32'h0);
`endif

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if_req    = 1'($urandom_range(0, 1));
      if_addr   = $urandom();
      d_req     = 1'($urandom_range(0, 1));
      d_we      = 1'($urandom_range(0, 1));
      d_addr    = $urandom();
      d_wdata   = $urandom();
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
      #1;
      chk1("rnd_stall", stall, (if_req && !m_if_rdy) || (d_req && !m_d_rdy));
      model_step();
      tick();
      chk1("rnd_mem_req", mem_req, m_busy);
      if (m_busy) begin
        chk32("rnd_mem_addr", mem_addr, m_addr);
        chk1("rnd_mem_we", mem_we, m_we);
        if (m_we) chk32("rnd_mem_wdata", mem_wdata, m_wdata);
      end
      chk1("rnd_if_ready", if_ready, m_if_rdy);
      chk1("rnd_d_ready", d_ready, m_d_rdy);
      chk1("rnd_ready_excl", if_ready & d_ready, 1'b0);
      chk32("rnd_if_rdata", if_rdata, m_if_rdata);
      chk32("rnd_d_rdata", d_rdata, m_d_rdata);
      chk1("rnd_err", err, m_err);
      chk32("rnd_err_addr", err_addr, m_err_addr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
